mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage directly downstream of the ALU. Takes the 32-bit ALU result (effective address for loads/stores, final result otherwise) plus decoded control. It runs a request/acknowledge transaction with data memory, aligns store data and byte enables, and sign- or zero-extends load data. It presents one registered writeback record per accepted instruction to the register-file stage.

## Interface
- ACK_TIMEOUT, 255: maximum cycles `dmem_req` stays high without `dmem_ack` before the access is aborted (1..255).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage presents an instruction.
- ex_ready  out  1  stage accepts this cycle; equals (state==IDLE).
- alu_c  in  32  ALU result C.
- store_data  in  32  rs2 value for stores.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- funct3  in  3  access size: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; other values are illegal for memory ops.
- rd  in  5  destination register.
- reg_write  in  1  instruction writes rd.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address {alu_c[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  memory completes the request this cycle; rdata is valid with the ack.
- dmem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_we  out  1  write rd; qualified by wb_valid.
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback value.
- misalign  out  1  one-cycle pulse coincident with wb_valid.
- bus_err  out  1  one-cycle pulse coincident with wb_valid.

## Operation
- FSM states: IDLE, WAIT.
- IDLE + ex_valid, non-memory op: register the record: wb_valid=1, wb_data=alu_c, wb_rd=rd, wb_we=reg_write&&(rd!=0). Stay in IDLE.
- IDLE + ex_valid, memory op, aligned: latch addr, funct3, rd, and write flag. Set dmem_req=1. Go to WAIT and clear the timeout counter.
- If mem_read and mem_write are both set, the instruction is a load; mem_write is ignored.
- Alignment rule: halfword requires addr[0]=0; word requires addr[1:0]=0; byte is always aligned. A misaligned op or an illegal funct3 issues no request. It retires next cycle with wb_valid=1, wb_we=0, misalign=1.
- Store lanes:
  - sb: be=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}.
  - sh: be=addr[1]?4'b1100:4'b0011, wdata={2{sd[15:0]}}.
  - sw: be=4'b1111, wdata=sd.
- Loads drive be=4'b1111 and we=0.
- WAIT + dmem_ack: drop dmem_req. Retire with wb_valid=1 and return to IDLE.
  - Load: wb_data = selected lane (rdata>>(8*addr[1:0])), sign-extended for lb/lh and zero-extended for lbu/lhu. wb_we=(rd!=0).
  - Store: wb_we=0, wb_data=0.
- WAIT without ack: counter increments each cycle. When the counter reaches ACK_TIMEOUT:
  - drop dmem_req;
  - retire with wb_valid=1, wb_we=0, bus_err=1;
  - return to IDLE.
- A late ack arriving in IDLE is ignored.
- wb_rd=0 always forces wb_we=0.

## Timing
- Reset values: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_we, wb_rd, wb_data, misalign, bus_err are all 0. State is IDLE and the counter is 0.
- ex_ready reads 1 while in reset; inputs are ignored while rst_n=0.
- Assertion of rst_n=0 in WAIT drops dmem_req asynchronously and abandons the access. No writeback is produced.
- Non-memory and misaligned ops have latency 1 (accept at edge N, wb_valid high after edge N) and a throughput of 1 per cycle.
- Memory ops:
  - dmem_req rises after accept edge N.
  - An ack sampled at edge N+k (k≥1) makes wb_valid high after edge N+k, and dmem_req low after the same edge.
  - ex_ready=0 from after edge N through edge N+k; the next accept can occur at edge N+k+1. Minimum memory-op latency is 2 cycles.
- dmem_addr, dmem_we, dmem_be, and dmem_wdata are stable for the whole time dmem_req=1.
- Timeout: with no ack, dmem_req is high for exactly ACK_TIMEOUT cycles, and bus_err/wb_valid pulse in the cycle after dmem_req falls.
- An ack in the same cycle the counter reaches ACK_TIMEOUT counts as success; no bus_err.
- All outputs are registered; no combinational path from ex_* or dmem_* inputs to outputs except ex_ready from state.

## Test plan
- ALU passthrough: 3 back-to-back non-mem ops with alu_c=0x11, 0x22, 0x33, rd=5, reg_write=1 -> wb_valid high 3 consecutive cycles, wb_data 0x11/0x22/0x33, ex_ready stays 1.
- lb/lbu: alu_c=0x1003, ack after 2 wait cycles with rdata=0x80FF_0000:
  - lb -> dmem_addr=0x1000, wb_data=0xFFFFFF80;
  - lbu -> wb_data=0x00000080.
- sh: alu_c=0x2002, store_data=0x1234ABCD, ack after 1 cycle -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1, wb_valid=1, wb_we=0.
- Misaligned lw at 0x2001 -> dmem_req never rises; the next cycle has wb_valid=1, misalign=1, wb_we=0.
- Timeout with ACK_TIMEOUT=4: load with no ack -> dmem_req high exactly 4 cycles, then wb_valid=1, bus_err=1. A late ack one cycle later produces no wb_valid.
- Reset in WAIT: assert rst_n=0 mid-access -> dmem_req falls without waiting for a clock edge. After release, the state is IDLE, ex_ready=1, and no wb_valid is produced for the abandoned op.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: aligns stores, extends loads, runs a req/ack handshake with data memory.
// Latency 1 for non-memory/misaligned ops, 2+ for memory ops; ex_ready is low while an access is outstanding.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_c,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [1:0] off;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       store;
  } acc_t;

  localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

  state_t      state, state_nxt;
  acc_t        acc_q, acc_nxt;
  logic [7:0]  cnt_q, cnt_nxt;
  logic [7:0]  cnt_inc;

  logic        dmem_req_nxt, dmem_we_nxt;
  logic [31:0] dmem_addr_nxt, dmem_wdata_nxt;
  logic [3:0]  dmem_be_nxt;
  logic        wb_valid_nxt, wb_we_nxt, misalign_nxt, bus_err_nxt;
  logic [4:0]  wb_rd_nxt;
  logic [31:0] wb_data_nxt;

  logic        is_mem, is_store, legal, aligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] lane;
  logic [31:0] ld_data;

  assign ex_ready = (state == IDLE);
  assign is_mem   = mem_read | mem_write;
  assign is_store = mem_write & ~mem_read;
  assign cnt_inc  = cnt_q + 8'd1;
  assign lane     = dmem_rdata >> {acc_q.off, 3'b000};

  // Store-only widths are 000/001/010; the unsigned encodings exist only for loads.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~is_store;
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned  = 1'b0;
    st_be    = 4'b1111;
    st_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        aligned  = 1'b1;
        st_be    = 4'b0001 << alu_c[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        aligned  = ~alu_c[0];
        st_be    = alu_c[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      2'b10: aligned = (alu_c[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    case (acc_q.funct3)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {24'd0, lane[7:0]};
      3'b101:  ld_data = {16'd0, lane[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc_q;
    cnt_nxt        = cnt_q;
    dmem_req_nxt   = dmem_req;
    dmem_we_nxt    = dmem_we;
    dmem_addr_nxt  = dmem_addr;
    dmem_wdata_nxt = dmem_wdata;
    dmem_be_nxt    = dmem_be;
    wb_valid_nxt   = 1'b0;
    wb_we_nxt      = 1'b0;
    wb_rd_nxt      = wb_rd;
    wb_data_nxt    = wb_data;
    misalign_nxt   = 1'b0;
    bus_err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wb_valid_nxt = 1'b1;
            wb_we_nxt    = reg_write && (rd != 5'd0);
            wb_rd_nxt    = rd;
            wb_data_nxt  = alu_c;
          end else if (!(legal && aligned)) begin
            wb_valid_nxt = 1'b1;
            misalign_nxt = 1'b1;
            wb_rd_nxt    = rd;
            wb_data_nxt  = 32'd0;
          end else begin
            acc_nxt        = '{off: alu_c[1:0], funct3: funct3, rd: rd, store: is_store};
            cnt_nxt        = 8'd0;
            dmem_req_nxt   = 1'b1;
            dmem_we_nxt    = is_store;
            dmem_addr_nxt  = {alu_c[31:2], 2'b00};
            dmem_be_nxt    = is_store ? st_be : 4'b1111;
            dmem_wdata_nxt = is_store ? st_wdata : 32'd0;
            state_nxt      = WAIT;
          end
        end
      end
      WAIT: begin
        // An ack on the final counted cycle wins over the timeout.
        if (dmem_ack) begin
          dmem_req_nxt = 1'b0;
          wb_valid_nxt = 1'b1;
          wb_rd_nxt    = acc_q.rd;
          wb_we_nxt    = ~acc_q.store && (acc_q.rd != 5'd0);
          wb_data_nxt  = acc_q.store ? 32'd0 : ld_data;
          state_nxt    = IDLE;
        end else if (cnt_inc == TIMEOUT) begin
          dmem_req_nxt = 1'b0;
          wb_valid_nxt = 1'b1;
          bus_err_nxt  = 1'b1;
          wb_rd_nxt    = acc_q.rd;
          wb_data_nxt  = 32'd0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc_q      <= '0;
      cnt_q      <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'd0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc_q      <= acc_nxt;
      cnt_q      <= cnt_nxt;
      dmem_req   <= dmem_req_nxt;
      dmem_we    <= dmem_we_nxt;
      dmem_addr  <= dmem_addr_nxt;
      dmem_wdata <= dmem_wdata_nxt;
      dmem_be    <= dmem_be_nxt;
      wb_valid   <= wb_valid_nxt;
      wb_we      <= wb_we_nxt;
      wb_rd      <= wb_rd_nxt;
      wb_data    <= wb_data_nxt;
      misalign   <= misalign_nxt;
      bus_err    <= bus_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] alu_c = '0, store_data = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign, bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_c(alu_c), .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .rd(rd), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [31:0] word, input int off, input logic [2:0] f3);
    logic [31:0] v;
    v = word >> (8 * off);
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'b001: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'b100: v = v & 32'hFF;
      3'b101: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  // Called at a falling edge; leaves the bench at the falling edge after retirement.
  task automatic run_op(input logic [31:0] c, input logic [31:0] sd, input logic mr, input logic mw,
                        input logic [2:0] f3, input logic [4:0] r, input logic rw,
                        input int ack_at, input logic [31:0] rdata, input bit late_ack);
    bit          is_mem, store, legal, bad;
    int          nbytes, off, retire_at;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, sdw;
    chk("ex_ready_accept", ex_ready, 1);
    ex_valid = 1; alu_c = c; store_data = sd; mem_read = mr; mem_write = mw;
    funct3 = f3; rd = r; reg_write = rw;
    @(negedge clk);
    is_mem = mr || mw;
    store  = mw && !mr;
    nbytes = 1 << f3[1:0];
    off    = int'(c % 4);
    legal  = store ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    bad    = !legal || (c % nbytes) != 0;
    if (!is_mem || bad) begin
      chk("wb_valid_fast", wb_valid, 1);
      chk("misalign_fast", misalign, bad && is_mem);
      chk("wb_we_fast", wb_we, !is_mem && rw && r != 0);
      chk("wb_rd_fast", wb_rd, r);
      if (!is_mem) chk("wb_data_alu", wb_data, c);
      chk("bus_err_fast", bus_err, 0);
      chk("no_req_fast", dmem_req, 0);
      return;
    end
    exp_be = 4'b0000;
    exp_wdata = 32'd0;
    sdw = sd;
    for (int i = 0; i < 4; i++) begin
      if (!store || (i >= off && i < off + nbytes)) exp_be[i] = 1'b1;
      exp_wdata[8*i +: 8] = sdw[8*(i % nbytes) +: 8];
    end
    retire_at = (ack_at <= T) ? ack_at : T;
    for (int k = 1; k <= retire_at; k++) begin
      chk("req_high", dmem_req, 1);
      chk("ex_ready_wait", ex_ready, 0);
      chk("wb_idle_wait", wb_valid, 0);
      chk("addr", dmem_addr, c & 32'hFFFF_FFFC);
      chk("we", dmem_we, store);
      chk("be", dmem_be, exp_be);
      if (store) chk("wdata", dmem_wdata, exp_wdata);
      ex_valid = $urandom % 2; alu_c = $urandom; store_data = $urandom;
      mem_read = $urandom % 2; mem_write = $urandom % 2; funct3 = 3'($urandom);
      dmem_ack = (k == ack_at);
      dmem_rdata = (k == ack_at) ? rdata : $urandom;
      @(negedge clk);
      dmem_ack = 0;
    end
    ex_valid = 0;
    chk("wb_valid_mem", wb_valid, 1);
    chk("req_dropped", dmem_req, 0);
    chk("ex_ready_back", ex_ready, 1);
    chk("bus_err", bus_err, ack_at > T);
    chk("misalign_mem", misalign, 0);
    chk("wb_rd_mem", wb_rd, r);
    if (ack_at > T || store) begin
      chk("wb_we_nowrite", wb_we, 0);
      if (store && ack_at <= T) chk("wb_data_store", wb_data, 0);
    end else begin
      chk("wb_we_load", wb_we, r != 0);
      chk("wb_data_load", wb_data, load_model(rdata, off, f3));
    end
    if (late_ack && ack_at > T) begin
      dmem_ack = 1; dmem_rdata = $urandom;
      @(negedge clk);
      dmem_ack = 0;
      chk("late_ack_ignored", wb_valid, 0);
      chk("late_ack_noreq", dmem_req, 0);
    end
  endtask

  task automatic idle_cycle(input bit ack);
    ex_valid = 0; alu_c = $urandom; mem_read = $urandom % 2; mem_write = $urandom % 2;
    dmem_ack = ack; dmem_rdata = $urandom;
    @(negedge clk);
    dmem_ack = 0;
    chk("idle_wb", wb_valid, 0);
    chk("idle_req", dmem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    bit mr, mw;
    // reset values, with inputs active to show they are ignored
    ex_valid = 1; mem_read = 1; alu_c = 32'h1000;
    repeat (2) @(negedge clk);
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_outs", {dmem_we, dmem_be, misalign, bus_err, wb_we, wb_rd}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_data", wb_data, 0);
    ex_valid = 0; mem_read = 0;
    rst_n = 1;
    idle_cycle(0);

    // passthrough, back to back
    run_op(32'h11, 0, 0, 0, 3'b000, 5'd5, 1, 0, 0, 0);
    run_op(32'h22, 0, 0, 0, 3'b000, 5'd5, 1, 0, 0, 0);
    run_op(32'h33, 0, 0, 0, 3'b000, 5'd5, 1, 0, 0, 0);
    idle_cycle(0);
    // lb / lbu with two wait cycles
    run_op(32'h1003, 0, 1, 0, 3'b000, 5'd7, 1, 3, 32'h80FF_0000, 0);
    run_op(32'h1003, 0, 1, 0, 3'b100, 5'd7, 1, 3, 32'h80FF_0000, 0);
    // sh upper half
    run_op(32'h2002, 32'h1234_ABCD, 0, 1, 3'b001, 5'd3, 1, 2, 0, 0);
    // misaligned lw, then illegal store width
    run_op(32'h2001, 0, 1, 0, 3'b010, 5'd9, 1, 1, 0, 0);
    run_op(32'h2000, 0, 0, 1, 3'b100, 5'd9, 1, 1, 0, 0);
    // timeout, late ack; then ack exactly at the limit
    run_op(32'h3000, 0, 1, 0, 3'b010, 5'd4, 1, 99, 0, 1);
    run_op(32'h3004, 0, 1, 1, 3'b010, 5'd4, 1, T, 32'hCAFE_F00D, 0);
    // load to x0 never writes
    run_op(32'h3008, 0, 1, 0, 3'b010, 5'd0, 1, 1, 32'h1, 0);

    // reset in WAIT
    ex_valid = 1; alu_c = 32'h4000; mem_read = 1; mem_write = 0; funct3 = 3'b010; rd = 5'd6;
    @(negedge clk);
    ex_valid = 0;
    @(negedge clk);
    chk("rstwait_req_before", dmem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("rstwait_req_async", dmem_req, 0);
    chk("rstwait_ready", ex_ready, 1);
    ex_valid = 1;
    @(negedge clk);
    ex_valid = 0;
    rst_n = 1;
    repeat (3) idle_cycle(1);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      mr = (kind >= 5 && kind <= 7) || (kind == 9 && ($urandom % 2) == 1);
      mw = (kind >= 8);
      if (kind < 2) idle_cycle($urandom % 2);
      else run_op($urandom, $urandom, mr, mw, 3'($urandom), 5'($urandom), $urandom % 2,
                  $urandom_range(1, T + 2), $urandom, $urandom % 2);
    end
    idle_cycle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
